// File: rtl/switch_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | switch_pkg : shared channel state encoding and counter width             |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
package switch_pkg;

    localparam int c_CNT_W    = 8;
    localparam int c_NUM_CHAN = 3;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } chan_state_t;

endpackage
`default_nettype wire

// File: rtl/switch_pulse_gen_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | switch_pulse_gen_if : raw switch inputs, press pulses, debounced levels  |
// | Revision            : 1.0                                                |
// +--------------------------------------------------------------------------+
interface switch_pulse_gen_if;

    logic       raw_s1;
    logic       raw_s2;
    logic       raw_s3;
    logic       S1;
    logic       S2;
    logic       S3;
    logic [2:0] level;

    modport master (
        output raw_s1, raw_s2, raw_s3,
        input  S1, S2, S3, level
    );

    modport slave (
        input  raw_s1, raw_s2, raw_s3,
        output S1, S2, S3, level
    );

endinterface
`default_nettype wire

// File: rtl/debounce_chan.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | debounce_chan : one switch channel - synchronizer, debounce FSM, pulse   |
// | Revision      : 1.0                                                      |
// +--------------------------------------------------------------------------+
module debounce_chan
    import switch_pkg::*;
#(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_raw,
    output logic o_pulse,
    output logic o_level
);

    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEB_CYCLES - 1);

    logic [1:0]         r_sync;
    logic               w_in;
    chan_state_t        r_state;
    chan_state_t        w_state_next;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_next;
    logic               r_pulse;
    logic               w_pulse_next;

    assign w_in = r_sync[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= 2'b00;
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_pulse <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_raw};
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_pulse <= w_pulse_next;
        end
    end

    // Counter clears on every transition, so it stops at c_CNT_LAST and never wraps.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = '0;
        w_pulse_next = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_in) w_state_next = ST_PRESS_WAIT;
            end
            ST_PRESS_WAIT: begin
                if (!w_in) begin
                    w_state_next = ST_IDLE;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_state_next = ST_PRESSED;
                    w_pulse_next = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + c_CNT_W'(1);
                end
            end
            ST_PRESSED: begin
                if (!w_in) w_state_next = ST_RELEASE_WAIT;
            end
            ST_RELEASE_WAIT: begin
                if (w_in) begin
                    w_state_next = ST_PRESSED;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_cnt_next = r_cnt + c_CNT_W'(1);
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign o_pulse = r_pulse;
    assign o_level = (r_state == ST_PRESSED) || (r_state == ST_RELEASE_WAIT);

endmodule
`default_nettype wire

// File: rtl/switch_pulse_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | switch_pulse_gen : three independent debounced switch-to-pulse channels  |
// | Revision         : 1.0                                                   |
// +--------------------------------------------------------------------------+
module switch_pulse_gen
    import switch_pkg::*;
#(
    parameter int DEB_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    switch_pulse_gen_if.slave  sw
);

    logic [c_NUM_CHAN-1:0] w_raw;
    logic [c_NUM_CHAN-1:0] w_pulse;
    logic [c_NUM_CHAN-1:0] w_level;

    assign w_raw = {sw.raw_s3, sw.raw_s2, sw.raw_s1};

    for (genvar gi = 0; gi < c_NUM_CHAN; gi++) begin : g_chan
        debounce_chan #(
            .DEB_CYCLES (DEB_CYCLES)
        ) u_chan (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_raw   (w_raw[gi]),
            .o_pulse (w_pulse[gi]),
            .o_level (w_level[gi])
        );
    end

    assign sw.S1    = w_pulse[0];
    assign sw.S2    = w_pulse[1];
    assign sw.S3    = w_pulse[2];
    assign sw.level = w_level;

endmodule
`default_nettype wire

// File: tb/tb_switch_pulse_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_switch_pulse_gen : directed bench, DEB_CYCLES=16 and DEB_CYCLES=1     |
// | Revision            : 1.0                                                |
// +--------------------------------------------------------------------------+
module tb_switch_pulse_gen;

    logic clk;
    logic rst_n;
    int   edge_n   = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cnt_a  [3] = '{0, 0, 0};
    int   last_a [3] = '{-1, -1, -1};
    int   cnt_b  [3] = '{0, 0, 0};
    int   last_b [3] = '{-1, -1, -1};

    switch_pulse_gen_if sw_a();
    switch_pulse_gen_if sw_b();

    switch_pulse_gen #(.DEB_CYCLES(16)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .sw    (sw_a.slave)
    );

    switch_pulse_gen #(.DEB_CYCLES(1)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .sw    (sw_b.slave)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    // Pulse monitor: every high sample counts, so a stretched pulse shows up as extra counts.
    always @(negedge clk) begin
        logic [2:0] pa;
        logic [2:0] pb;
        pa = {sw_a.S3, sw_a.S2, sw_a.S1};
        pb = {sw_b.S3, sw_b.S2, sw_b.S1};
        for (int i = 0; i < 3; i++) begin
            if (pa[i] !== 1'b0) begin cnt_a[i]++; last_a[i] = edge_n; end
            if (pb[i] !== 1'b0) begin cnt_b[i]++; last_b[i] = edge_n; end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_b(input int ch, input logic v);
        case (ch)
            0:       sw_b.raw_s1 = v;
            1:       sw_b.raw_s2 = v;
            default: sw_b.raw_s3 = v;
        endcase
    endtask

    initial begin
        int e0;
        int base1;
        int base3;
        int ok;
        int eb [3];

        rst_n = 1'b0;
        sw_a.raw_s1 = 1'b0; sw_a.raw_s2 = 1'b0; sw_a.raw_s3 = 1'b0;
        sw_b.raw_s1 = 1'b0; sw_b.raw_s2 = 1'b0; sw_b.raw_s3 = 1'b0;

        wait_n(2);
        chk("rst_pulses_a", {29'd0, sw_a.S3, sw_a.S2, sw_a.S1}, 32'd0);
        chk("rst_level_a", {29'd0, sw_a.level}, 32'd0);
        chk("rst_level_b", {29'd0, sw_b.level}, 32'd0);
        rst_n = 1'b1;
        wait_n(3);

        // Clean press on s1
        sw_a.raw_s1 = 1'b1; e0 = edge_n + 1;
        wait_n(40);
        chk("s1_count", cnt_a[0], 1);
        chk("s1_latency", last_a[0], e0 + 18);
        chk("s1_level", {31'd0, sw_a.level[0]}, 1);
        chk("s1_others_quiet", cnt_a[1] + cnt_a[2], 0);
        sw_a.raw_s1 = 1'b0;
        wait_n(30);
        chk("s1_level_released", {31'd0, sw_a.level[0]}, 0);
        chk("s1_no_release_pulse", cnt_a[0], 1);

        // Bounced press on s2
        sw_a.raw_s2 = 1'b1; wait_n(10);
        sw_a.raw_s2 = 1'b0; wait_n(3);
        sw_a.raw_s2 = 1'b1; e0 = edge_n + 1;
        wait_n(30);
        chk("s2_count", cnt_a[1], 1);
        chk("s2_latency", last_a[1], e0 + 18);
        chk("s2_level", {31'd0, sw_a.level[1]}, 1);
        sw_a.raw_s2 = 1'b0;
        wait_n(30);
        chk("s2_level_released", {31'd0, sw_a.level[1]}, 0);

        // Long hold on s3 with a short release bounce
        sw_a.raw_s3 = 1'b1;
        wait_n(25);
        ok = 1;
        for (int i = 0; i < 975; i++) begin
            @(negedge clk);
            if (sw_a.level[2] !== 1'b1) ok = 0;
        end
        sw_a.raw_s3 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (sw_a.level[2] !== 1'b1) ok = 0;
        end
        sw_a.raw_s3 = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (sw_a.level[2] !== 1'b1) ok = 0;
        end
        chk("s3_level_held", ok, 1);
        chk("s3_single_pulse", cnt_a[2], 1);
        sw_a.raw_s3 = 1'b0;
        wait_n(30);
        chk("s3_level_released", {31'd0, sw_a.level[2]}, 0);

        // Coincident presses on s1 and s3
        base1 = cnt_a[0]; base3 = cnt_a[2];
        sw_a.raw_s1 = 1'b1; sw_a.raw_s3 = 1'b1; e0 = edge_n + 1;
        wait_n(25);
        chk("coinc_s1_edge", last_a[0], e0 + 18);
        chk("coinc_s3_edge", last_a[2], e0 + 18);
        chk("coinc_s1_count", cnt_a[0] - base1, 1);
        chk("coinc_s3_count", cnt_a[2] - base3, 1);
        chk("coinc_level", {29'd0, sw_a.level}, 32'd5);
        sw_a.raw_s1 = 1'b0; sw_a.raw_s3 = 1'b0;
        wait_n(30);

        // Reset during debounce, switch held across release
        base1 = cnt_a[0];
        sw_a.raw_s1 = 1'b1; e0 = edge_n + 1;
        wait_n(12);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outputs", {26'd0, sw_a.S3, sw_a.S2, sw_a.S1, sw_a.level}, 32'd0);
        wait_n(3);
        chk("rst_mid_no_pulse", cnt_a[0] - base1, 0);
        rst_n = 1'b1; e0 = edge_n + 1;
        wait_n(25);
        chk("rst_after_count", cnt_a[0] - base1, 1);
        chk("rst_after_latency", last_a[0], e0 + 18);
        sw_a.raw_s1 = 1'b0;
        wait_n(30);

        // DEB_CYCLES=1: S1, S2, S3 presses 300 cycles (6000 ns) apart
        for (int ch = 0; ch < 3; ch++) begin
            set_b(ch, 1'b1); eb[ch] = edge_n + 1;
            wait_n(20);
            set_b(ch, 1'b0);
            wait_n(280);
        end
        for (int ch = 0; ch < 3; ch++) begin
            chk($sformatf("fast_count_%0d", ch), cnt_b[ch], 1);
            chk($sformatf("fast_latency_%0d", ch), last_b[ch], eb[ch] + 3);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/switch_pulse_gen.md
SWITCH_PULSE_GEN -- requirements
Module: switch_pulse_gen

Interface
REQ-001 The block SHALL have parameter DEB_CYCLES, default 16, meaning the stable-level cycles required to accept a switch transition; legal range is 1..255.
REQ-002 The block SHALL have port clk, input, 1 bit: single rising-edge clock for all state.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port raw_s1, input, 1 bit: unsynchronized mechanical switch 1, active-high, may bounce.
REQ-005 The block SHALL have port raw_s2, input, 1 bit: unsynchronized switch 2, same semantics.
REQ-006 The block SHALL have port raw_s3, input, 1 bit: unsynchronized switch 3, same semantics.
REQ-007 The block SHALL have port S1, output, 1 bit: one-cycle press pulse for the lamp controller's S1 input.
REQ-008 The block SHALL have ports S2 and S3, output, 1 bit each: one-cycle press pulses, same semantics.
REQ-009 The block SHALL have port level, output, 3 bits: debounced switch levels, bit0=s1, bit1=s2, bit2=s3.

Function
REQ-010 The three channels SHALL be identical and independent; no channel affects another.
REQ-011 Each raw input SHALL pass through a 2-flop synchronizer before any other logic.
REQ-012 Each channel SHALL run FSM IDLE -> PRESS_WAIT -> PRESSED -> RELEASE_WAIT -> IDLE.
REQ-013 IDLE SHALL move to PRESS_WAIT when the synchronized input is 1, with the 8-bit counter cleared.
REQ-014 PRESS_WAIT SHALL increment the counter each cycle the synchronized input is 1, and return to IDLE with the counter cleared on any 0.
REQ-015 PRESS_WAIT SHALL move to PRESSED on the edge at which the counter reaches DEB_CYCLES-1 with the input still 1.
REQ-016 The Sx pulse SHALL be high for exactly the one cycle after entry to PRESSED; level bit SHALL go 1 at that same edge.
REQ-017 Press latency SHALL be exactly 2+DEB_CYCLES clk edges from the first edge that samples raw high, provided raw stays high throughout.
REQ-018 PRESSED, RELEASE_WAIT and RELEASE_WAIT-to-IDLE SHALL mirror REQ-013..015 for input 0; level bit SHALL clear on entry to IDLE; release SHALL produce no pulse.
REQ-019 A bounce in RELEASE_WAIT (input 1) SHALL return to PRESSED with no new pulse.
REQ-020 A held switch SHALL produce exactly one pulse; the next pulse SHALL require a debounced release first.
REQ-021 Presses on several channels completing on the same edge SHALL produce coincident pulses.
REQ-022 Counter SHALL saturate logic-wise by the FSM transition; it SHALL never wrap.

Reset
REQ-023 rst_n low SHALL immediately force every FSM to IDLE, counters and synchronizer flops to 0, S1/S2/S3 to 0, level to 3'b000.
REQ-024 Reset asserted mid-debounce or mid-pulse SHALL abort it with no pulse emitted.
REQ-025 A switch held high across reset release SHALL be treated as a new press and emit one pulse after 2+DEB_CYCLES edges.

Structure
REQ-026 The FSM state encoding and counter width (8) SHALL live in shared package switch_pkg.
REQ-027 One channel (synchronizer, counter, FSM, pulse) SHALL be sub-module debounce_chan, instantiated three times.

Verification
REQ-028 DEB_CYCLES=16, raw_s1 clean high for 40 cycles -> S1 high for one cycle 18 edges after first sampled high, level[0]=1; S2=S3=0.
REQ-029 raw_s2 high 10 cycles, low 3, high 30 (DEB_CYCLES=16) -> exactly one S2 pulse, 18 edges after the second rising sample.
REQ-030 raw_s3 held high 1000 cycles, then low 5 cycles, then high 40 -> one pulse only; level[2] stays 1 throughout.
REQ-031 raw_s1 and raw_s3 rise on the same edge, clean -> S1 and S3 pulse on the same cycle.
REQ-032 rst_n low at edge 10 of PRESS_WAIT for raw_s1 -> no pulse, all outputs 0 immediately; after release with raw_s1 still high, one pulse 18 edges later.
REQ-033 DEB_CYCLES=1 -> pulse 3 edges after raw rises; sequence S1, S2, S3 presses 6000 ns apart at 20 ns clock -> three single-cycle pulses in order.
